cellrv32_cpu_cp_dispatch: RTL and testbench

//  CPU-side initiator for the co-processor start/valid interface. Takes an issue request from the

---
 rtl/cellrv32_package.sv | 23 ++
 rtl/cellrv32_cpu_cp_dispatch.sv | 124 ++++++++++++
 tb/tb_cellrv32_cpu_cp_dispatch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cellrv32_package.sv
// Shared definitions for the CPU co-processor dispatch path: FSM state type,
// co-processor slot assignments and the default watchdog length.
package cellrv32_package;

  typedef enum logic [1:0] {
    CPD_IDLE,
    CPD_START,
    CPD_WAIT,
    CPD_CAPTURE
  } cp_disp_state_t;

  localparam int cp_sel_shifter_c  = 0;
  localparam int cp_sel_muldiv_c   = 1;
  localparam int cp_sel_cond_c     = 2;
  localparam int cp_sel_bitmanip_c = 3;
  localparam int cp_sel_fpu_c      = 4;
  localparam int cp_sel_cfu_c      = 5;
  localparam int cp_sel_crypto_c   = 6;
  localparam int cp_sel_rsvd_c     = 7;

  localparam int cp_tmo_default_c  = 128;

endpackage

// File: rtl/cellrv32_cpu_cp_dispatch.sv
// Co-processor initiator: start pulse to one slot, wait for its valid, capture the
// registered result and report done, or report a timeout if the slot never answers.
module cellrv32_cpu_cp_dispatch
  import cellrv32_package::*;
#(
  parameter int XLEN       = 32,
  parameter int NCP        = 8,
  parameter int TMO_CYCLES = cp_tmo_default_c
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    issue_i,
  input  logic [$clog2(NCP)-1:0]  cp_id_i,
  input  logic                    kill_i,
  output logic [NCP-1:0]          cp_start_o,
  input  logic [NCP-1:0]          cp_valid_i,
  input  logic [NCP*XLEN-1:0]     cp_res_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         res_o,
  output logic                    tmo_o
);

  localparam int IDW  = $clog2(NCP);
  localparam int IDW1 = IDW + 1;
  localparam int CNTW = $clog2(TMO_CYCLES);

  localparam logic [IDW:0]    NCP_W    = IDW1'(NCP);
  // Counter is cleared on entering WAIT, so the last WAIT cycle sees TMO_CYCLES-2;
  // that puts the timeout pulse exactly TMO_CYCLES cycles after the start pulse.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TMO_CYCLES - 2);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  cp_disp_state_t  state_reg, state_next;
  logic [IDW-1:0]  id_reg, id_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0] res_reg, res_next;
  logic            done_reg, done_next;
  logic            tmo_reg, tmo_next;

  logic [XLEN-1:0] slot_res [NCP];
  logic            sel_valid;

  for (genvar gi = 0; gi < NCP; gi++) begin : g_slot
    assign slot_res[gi]   = cp_res_i[gi*XLEN +: XLEN];
    assign cp_start_o[gi] = (state_reg == CPD_START) && (id_reg == IDW'(gi));
  end

  // Only the latched slot is ever observed; other valids are don't-care.
  assign sel_valid = cp_valid_i[id_reg];

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;
    done_next  = 1'b0;
    tmo_next   = 1'b0;
    case (state_reg)
      CPD_IDLE: begin
        if (issue_i && !kill_i) begin
          if ({1'b0, cp_id_i} < NCP_W) begin
            id_next    = cp_id_i;
            state_next = CPD_START;
          end else begin
            tmo_next = 1'b1;
          end
        end
      end
      CPD_START: begin
        cnt_next = '0;
        if (kill_i)         state_next = CPD_IDLE;
        else if (sel_valid) state_next = CPD_CAPTURE;
        else                state_next = CPD_WAIT;
      end
      CPD_WAIT: begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        if (kill_i) begin
          state_next = CPD_IDLE;
        end else if (sel_valid) begin
          state_next = CPD_CAPTURE;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = CPD_IDLE;
          tmo_next   = 1'b1;
        end
      end
      CPD_CAPTURE: begin
        state_next = CPD_IDLE;
        if (!kill_i) begin
          res_next  = slot_res[id_reg];
          done_next = 1'b1;
        end
      end
      default: state_next = CPD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= CPD_IDLE;
      id_reg    <= '0;
      cnt_reg   <= '0;
      res_reg   <= '0;
      done_reg  <= 1'b0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
      done_reg  <= done_next;
      tmo_reg   <= tmo_next;
    end
  end

  assign busy_o = (state_reg != CPD_IDLE);
  assign done_o = done_reg;
  assign tmo_o  = tmo_reg;
  assign res_o  = res_reg;

  // A new request while an operation is in flight is dropped by the FSM.
  assert property (@(posedge clk_i) disable iff (!rstn_i) !(issue_i && busy_o));

endmodule

// File: tb/tb_cellrv32_cpu_cp_dispatch.sv
// Bench for the co-processor dispatcher: per-operation outcomes are predicted from
// issue/valid/kill timing relative to the issue cycle and compared cycle by cycle.
module tb_cellrv32_cpu_cp_dispatch;

  localparam int XLEN = 32;
  localparam int NCP  = 6;
  localparam int TMO  = 16;
  localparam int IDW  = $clog2(NCP);

  logic                 clk;
  logic                 rstn;
  logic                 issue;
  logic [IDW-1:0]       cp_id;
  logic                 kill;
  logic [NCP-1:0]       cp_start;
  logic [NCP-1:0]       cp_valid;
  logic [NCP*XLEN-1:0]  cp_res;
  logic                 busy;
  logic                 done;
  logic [XLEN-1:0]      res;
  logic                 tmo;

  cellrv32_cpu_cp_dispatch #(
    .XLEN       (XLEN),
    .NCP        (NCP),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .issue_i    (issue),
    .cp_id_i    (cp_id),
    .kill_i     (kill),
    .cp_start_o (cp_start),
    .cp_valid_i (cp_valid),
    .cp_res_i   (cp_res),
    .busy_o     (busy),
    .done_o     (done),
    .res_o      (res),
    .tmo_o      (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] res_model = '0;
  bit          pend_done = 1'b0;
  bit          pend_tmo  = 1'b0;
  int          obs_start_cnt = 0;
  int          obs_done_cnt  = 0;
  int          obs_tmo_cnt   = 0;

  // Random traffic on every slot; slot id gets the scheduled valid/result.
  task automatic drive_cp(input int id, input bit v, input bit rv, input logic [31:0] val);
    for (int k = 0; k < NCP; k++) begin
      cp_res[k*XLEN +: XLEN] = $urandom;
      cp_valid[k] = ($urandom_range(0, 1) == 1);
    end
    if (id < NCP) begin
      cp_valid[id] = v;
      if (rv) cp_res[id*XLEN +: XLEN] = val;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      issue = 1'b0;
      kill  = ($urandom_range(0, 1) == 1);
      cp_id = IDW'($urandom);
      drive_cp(NCP, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_vec += 5;
      if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
      if (cp_start !== '0) begin n_err++; $display("FAIL idle_start got=%b exp=0", cp_start); end
      if (done !== pend_done) begin n_err++; $display("FAIL idle_done got=%b exp=%b", done, pend_done); end
      if (tmo !== pend_tmo) begin n_err++; $display("FAIL idle_tmo got=%b exp=%b", tmo, pend_tmo); end
      if (res !== res_model) begin n_err++; $display("FAIL idle_res got=%h exp=%h", res, res_model); end
      if (done === 1'b1) obs_done_cnt++;
      if (tmo === 1'b1) obs_tmo_cnt++;
      pend_done = 1'b0;
      pend_tmo  = 1'b0;
    end
  endtask

  // One operation. Cycle 0 = issue cycle; vdelay = cycles from start pulse to valid
  // (-1: never); kill_at = cycle index where kill is raised (-1: never).
  task automatic run_op(input int id, input int vdelay, input logic [31:0] val, input int kill_at);
    bit invalid, dropped, hit, killed, started;
    int nat_end, busy_end, last;
    logic [NCP-1:0] exp_start;
    invalid  = (id >= NCP);
    dropped  = (kill_at == 0);
    hit      = !invalid && vdelay >= 0 && vdelay <= TMO - 1;
    nat_end  = invalid ? 1 : (hit ? vdelay + 3 : TMO + 1);
    started  = !invalid && !dropped;
    killed   = started && kill_at > 0 && kill_at < nat_end;
    busy_end = killed ? kill_at + 1 : (started ? nat_end : 0);
    last     = killed ? kill_at + 1 : (dropped ? 0 : nat_end - 1);
    for (int j = 0; j <= last; j++) begin
      @(posedge clk); #1;
      issue = (j == 0);
      kill  = (j == kill_at);
      cp_id = (j == 0) ? IDW'(id) : IDW'($urandom);
      drive_cp(id, started && vdelay >= 0 && j == vdelay + 1, j == vdelay + 2, val);
      @(negedge clk);
      exp_start = (started && j == 1) ? (NCP'(1) << id) : '0;
      n_vec += 5;
      if (cp_start !== exp_start) begin
        n_err++; $display("FAIL op_start id=%0d cyc=%0d got=%b exp=%b", id, j, cp_start, exp_start);
      end
      if (busy !== (started && j >= 1 && j < busy_end)) begin
        n_err++; $display("FAIL op_busy id=%0d cyc=%0d got=%b exp=%b", id, j, busy, (started && j >= 1 && j < busy_end));
      end
      if (done !== (j == 0 && pend_done)) begin
        n_err++; $display("FAIL op_done id=%0d cyc=%0d got=%b exp=%b", id, j, done, (j == 0 && pend_done));
      end
      if (tmo !== (j == 0 && pend_tmo)) begin
        n_err++; $display("FAIL op_tmo id=%0d cyc=%0d got=%b exp=%b", id, j, tmo, (j == 0 && pend_tmo));
      end
      if (res !== res_model) begin
        n_err++; $display("FAIL op_res id=%0d cyc=%0d got=%h exp=%h", id, j, res, res_model);
      end
      if (cp_start !== '0) obs_start_cnt++;
      if (done === 1'b1) obs_done_cnt++;
      if (tmo === 1'b1) obs_tmo_cnt++;
      if (j == 0) begin
        pend_done = 1'b0;
        pend_tmo  = 1'b0;
      end
    end
    if (!dropped && !killed) begin
      if (hit) begin
        pend_done = 1'b1;
        res_model = val;
      end else begin
        pend_tmo = 1'b1;
      end
    end
  endtask

  task automatic clear_obs();
    obs_start_cnt = 0;
    obs_done_cnt  = 0;
    obs_tmo_cnt   = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; issue = 1'b0; kill = 1'b0; cp_id = '0;
    drive_cp(NCP, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    n_vec += 5;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (cp_start !== '0) begin n_err++; $display("FAIL reset_start got=%b exp=0", cp_start); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    if (tmo !== 1'b0) begin n_err++; $display("FAIL reset_tmo got=%b exp=0", tmo); end
    if (res !== '0) begin n_err++; $display("FAIL reset_res got=%h exp=0", res); end
    rstn = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_zicond();
    clear_obs();
    run_op(2, 0, 32'h1234_5678, -1);
    idle_cycles(2);
    n_vec += 2;
    if (obs_start_cnt !== 1) begin n_err++; $display("FAIL zicond_starts got=%0d exp=1", obs_start_cnt); end
    if (obs_done_cnt !== 1) begin n_err++; $display("FAIL zicond_dones got=%0d exp=1", obs_done_cnt); end
  endtask

  task automatic test_multicycle();
    clear_obs();
    run_op(5, 6, 32'hDEAD_BEEF, -1);
    idle_cycles(3);
    n_vec += 3;
    if (obs_start_cnt !== 1) begin n_err++; $display("FAIL multi_starts got=%0d exp=1", obs_start_cnt); end
    if (obs_done_cnt !== 1) begin n_err++; $display("FAIL multi_dones got=%0d exp=1", obs_done_cnt); end
    if (res !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL multi_res got=%h exp=deadbeef", res); end
  endtask

  task automatic test_timeout();
    clear_obs();
    run_op(1, -1, 32'h0BAD_F00D, -1);
    idle_cycles(2);
    // valid on the terminal WAIT cycle still wins, one cycle later it is too late
    run_op(3, TMO - 1, 32'hA5A5_0001, -1);
    run_op(4, TMO, 32'hA5A5_0002, -1);
    idle_cycles(2);
    n_vec += 3;
    if (obs_tmo_cnt !== 2) begin n_err++; $display("FAIL tmo_count got=%0d exp=2", obs_tmo_cnt); end
    if (obs_done_cnt !== 1) begin n_err++; $display("FAIL tmo_dones got=%0d exp=1", obs_done_cnt); end
    if (res !== 32'hA5A5_0001) begin n_err++; $display("FAIL tmo_res got=%h exp=a5a50001", res); end
  endtask

  task automatic test_kill();
    clear_obs();
    run_op(3, 4, 32'h5555_AAAA, 4);
    run_op(0, 0, 32'h1111_2222, 1);
    run_op(2, 0, 32'h3333_4444, 2);
    run_op(4, 0, 32'h7777_8888, 0);
    run_op(3, 1, 32'hCAFE_0003, -1);
    idle_cycles(2);
    n_vec += 3;
    if (obs_done_cnt !== 1) begin n_err++; $display("FAIL kill_dones got=%0d exp=1", obs_done_cnt); end
    if (obs_tmo_cnt !== 0) begin n_err++; $display("FAIL kill_tmos got=%0d exp=0", obs_tmo_cnt); end
    if (obs_start_cnt !== 4) begin n_err++; $display("FAIL kill_starts got=%0d exp=4", obs_start_cnt); end
  endtask

  task automatic test_bad_id();
    clear_obs();
    run_op(7, 0, 32'hFFFF_0007, -1);
    run_op(6, 0, 32'hFFFF_0006, -1);
    idle_cycles(2);
    n_vec += 2;
    if (obs_start_cnt !== 0) begin n_err++; $display("FAIL badid_starts got=%0d exp=0", obs_start_cnt); end
    if (obs_tmo_cnt !== 2) begin n_err++; $display("FAIL badid_tmos got=%0d exp=2", obs_tmo_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    run_op(4, 0, 32'h0404_0404, -1);
    run_op(0, 3, 32'h0000_00AA, -1);
    run_op(5, 0, 32'h0505_0505, -1);
    idle_cycles(1);
    n_vec += 2;
    if (obs_done_cnt !== 3) begin n_err++; $display("FAIL b2b_dones got=%0d exp=3", obs_done_cnt); end
    if (obs_start_cnt !== 3) begin n_err++; $display("FAIL b2b_starts got=%0d exp=3", obs_start_cnt); end
  endtask

  task automatic test_async_reset();
    idle_cycles(1);
    @(posedge clk); #1;
    issue = 1'b1; kill = 1'b0; cp_id = IDW'(4);
    drive_cp(4, 1'b0, 1'b0, '0);
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      issue = 1'b0;
      drive_cp(4, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy cyc=%0d got=%b exp=1", j, busy); end
    end
    #2 rstn = 1'b0;
    #1;
    n_vec += 5;
    if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=0", busy); end
    if (cp_start !== '0) begin n_err++; $display("FAIL arst_start got=%b exp=0", cp_start); end
    if (done !== 1'b0) begin n_err++; $display("FAIL arst_done got=%b exp=0", done); end
    if (tmo !== 1'b0) begin n_err++; $display("FAIL arst_tmo got=%b exp=0", tmo); end
    if (res !== '0) begin n_err++; $display("FAIL arst_res got=%h exp=0", res); end
    res_model = '0;
    pend_done = 1'b0;
    pend_tmo  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle_cycles(2);
    run_op(4, 1, 32'h4444_0001, -1);
    idle_cycles(1);
  endtask

  task automatic test_random();
    int id, vd, ka, gap;
    for (int n = 0; n < 40; n++) begin
      id  = $urandom_range(0, 7);
      vd  = int'($urandom_range(0, TMO + 2)) - 1;
      ka  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      gap = $urandom_range(0, 2);
      run_op(id, vd, $urandom, ka);
      idle_cycles(gap);
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_zicond();
    test_multicycle();
    test_timeout();
    test_kill();
    test_bad_id();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
